// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage.
// This includes the ALU opcodes, the source-select encodings and the forwarding-hit helper.
package id_ex_operand_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_t;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_UIMM = 2'd1,
        SRCA_PC   = 2'd2,
        SRCA_ZERO = 2'd3
    } srca_sel_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IIMM = 2'd1,
        SRCB_SIMM = 2'd2,
        SRCB_PC   = 2'd3
    } srcb_sel_t;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
        logic memwrite;
    } ex_ctrl_t;

    // A writer to x0 must never forward: x0 is hardwired to zero.
    function automatic logic fwd_hit(input logic              we,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
        return we && (rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of decode fields, forwarding sources and EX-side outputs for the ID/EX stage.
// The master is the surrounding pipeline, and the slave is the stage itself.
interface id_ex_operand_stage_if;
    import id_ex_operand_stage_pkg::*;

    logic              stall;
    logic              flush;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [REG_AW-1:0] id_rs1_addr;
    logic [REG_AW-1:0] id_rs2_addr;
    logic [REG_AW-1:0] id_rd_addr;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_imm_i;
    logic [XLEN-1:0]   id_imm_s;
    logic [XLEN-1:0]   id_imm_u;
    logic [3:0]        id_alu_fun;
    logic [1:0]        id_srcA_sel;
    logic [1:0]        id_srcB_sel;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_memwrite;

    logic              exm_regwrite;
    logic [REG_AW-1:0] exm_rd_addr;
    logic [XLEN-1:0]   exm_result;
    logic              mwb_regwrite;
    logic [REG_AW-1:0] mwb_rd_addr;
    logic [XLEN-1:0]   mwb_result;

    logic [3:0]        alu_fun;
    logic [XLEN-1:0]   srcA;
    logic [XLEN-1:0]   srcB;
    logic [XLEN-1:0]   ex_store_data;
    logic [XLEN-1:0]   ex_pc;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_valid;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              ex_memwrite;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm_i, id_imm_s, id_imm_u, id_alu_fun,
               id_srcA_sel, id_srcB_sel, id_regwrite, id_memread, id_memwrite,
               exm_regwrite, exm_rd_addr, exm_result, mwb_regwrite, mwb_rd_addr, mwb_result,
        input  alu_fun, srcA, srcB, ex_store_data, ex_pc, ex_rd_addr,
               ex_valid, ex_regwrite, ex_memread, ex_memwrite
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm_i, id_imm_s, id_imm_u, id_alu_fun,
               id_srcA_sel, id_srcB_sel, id_regwrite, id_memread, id_memwrite,
               exm_regwrite, exm_rd_addr, exm_result, mwb_regwrite, mwb_rd_addr, mwb_result,
        output alu_fun, srcA, srcB, ex_store_data, ex_pc, ex_rd_addr,
               ex_valid, ex_regwrite, ex_memread, ex_memwrite
    );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-operand RAW forwarding: the youngest matching producer wins, falling back to regfile data.
module id_ex_operand_stage_fwd_mux
    import id_ex_operand_stage_pkg::*;
(
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rs_data,
    input  logic              exm_regwrite,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic [XLEN-1:0]   exm_result,
    input  logic              mwb_regwrite,
    input  logic [REG_AW-1:0] mwb_rd_addr,
    input  logic [XLEN-1:0]   mwb_result,
    output logic [XLEN-1:0]   fwd_data
);

    always_comb begin
        fwd_data = rs_data;
        if (fwd_hit(exm_regwrite, exm_rd_addr, rs_addr)) begin
            fwd_data = exm_result;
        end else if (fwd_hit(mwb_regwrite, mwb_rd_addr, rs_addr)) begin
            fwd_data = mwb_result;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with stall/flush and forwarded ALU operand selection.
// The ALU inputs and the store data are combinational from registered state plus the forwarding buses.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST_N,
    id_ex_operand_stage_if.slave bus
);

    ex_ctrl_t          ctrl_reg;
    ex_ctrl_t          ctrl_next;
    logic [XLEN-1:0]   pc_reg;
    logic [REG_AW-1:0] rd_reg;
    logic [XLEN-1:0]   imm_i_reg;
    logic [XLEN-1:0]   imm_s_reg;
    logic [XLEN-1:0]   imm_u_reg;
    alu_fun_t          alu_fun_reg;
    srca_sel_t         srca_sel_reg;
    srcb_sel_t         srcb_sel_reg;

    logic [REG_AW-1:0] id_rs_addr [2];
    logic [XLEN-1:0]   id_rs_data [2];
    logic [XLEN-1:0]   rs1_fwd;
    logic [XLEN-1:0]   rs2_fwd;

    assign id_rs_addr[0] = bus.id_rs1_addr;
    assign id_rs_addr[1] = bus.id_rs2_addr;
    assign id_rs_data[0] = bus.id_rs1_data;
    assign id_rs_data[1] = bus.id_rs2_data;

    // Downstream side effects only happen for real instructions.
    always_comb begin
        ctrl_next          = '0;
        ctrl_next.valid    = bus.id_valid;
        ctrl_next.regwrite = bus.id_regwrite & bus.id_valid;
        ctrl_next.memread  = bus.id_memread  & bus.id_valid;
        ctrl_next.memwrite = bus.id_memwrite & bus.id_valid;
    end

    // A flush outranks a stall, so a bubble is always inserted even while the stage holds.
    always_ff @(posedge CLK) begin
        if (!RST_N || bus.flush) begin
            ctrl_reg     <= '0;
            pc_reg       <= '0;
            rd_reg       <= '0;
            imm_i_reg    <= '0;
            imm_s_reg    <= '0;
            imm_u_reg    <= '0;
            alu_fun_reg  <= ALU_ADD;
            srca_sel_reg <= SRCA_RS1;
            srcb_sel_reg <= SRCB_RS2;
        end else if (!bus.stall) begin
            ctrl_reg     <= ctrl_next;
            pc_reg       <= bus.id_pc;
            rd_reg       <= bus.id_rd_addr;
            imm_i_reg    <= bus.id_imm_i;
            imm_s_reg    <= bus.id_imm_s;
            imm_u_reg    <= bus.id_imm_u;
            alu_fun_reg  <= alu_fun_t'(bus.id_alu_fun);
            srca_sel_reg <= srca_sel_t'(bus.id_srcA_sel);
            srcb_sel_reg <= srcb_sel_t'(bus.id_srcB_sel);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic [REG_AW-1:0] rs_addr_reg;
            logic [XLEN-1:0]   rs_data_reg;
            logic [XLEN-1:0]   fwd_data;

            always_ff @(posedge CLK) begin
                if (!RST_N || bus.flush) begin
                    rs_addr_reg <= '0;
                    rs_data_reg <= '0;
                end else if (!bus.stall) begin
                    rs_addr_reg <= id_rs_addr[gi];
                    rs_data_reg <= id_rs_data[gi];
                end
            end

            id_ex_operand_stage_fwd_mux u_fwd (
                .rs_addr      (rs_addr_reg),
                .rs_data      (rs_data_reg),
                .exm_regwrite (bus.exm_regwrite),
                .exm_rd_addr  (bus.exm_rd_addr),
                .exm_result   (bus.exm_result),
                .mwb_regwrite (bus.mwb_regwrite),
                .mwb_rd_addr  (bus.mwb_rd_addr),
                .mwb_result   (bus.mwb_result),
                .fwd_data     (fwd_data)
            );
        end
    endgenerate

    assign rs1_fwd = g_operand[0].fwd_data;
    assign rs2_fwd = g_operand[1].fwd_data;

    always_comb begin
        bus.srcA = '0;
        case (srca_sel_reg)
            SRCA_RS1:  bus.srcA = rs1_fwd;
            SRCA_UIMM: bus.srcA = imm_u_reg;
            SRCA_PC:   bus.srcA = pc_reg;
            default:   bus.srcA = '0;
        endcase
    end

    always_comb begin
        bus.srcB = '0;
        case (srcb_sel_reg)
            SRCB_RS2:  bus.srcB = rs2_fwd;
            SRCB_IIMM: bus.srcB = imm_i_reg;
            SRCB_SIMM: bus.srcB = imm_s_reg;
            default:   bus.srcB = pc_reg;
        endcase
    end

    assign bus.alu_fun       = alu_fun_reg;
    assign bus.ex_store_data = rs2_fwd;
    assign bus.ex_pc         = pc_reg;
    assign bus.ex_rd_addr    = rd_reg;
    assign bus.ex_valid      = ctrl_reg.valid;
    assign bus.ex_regwrite   = ctrl_reg.regwrite;
    assign bus.ex_memread    = ctrl_reg.memread;
    assign bus.ex_memwrite   = ctrl_reg.memwrite;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed, table-driven bench for the ID/EX operand stage with hand sequences for reset, hold and bubble.
module tb_id_ex_operand_stage;

    logic CLK;
    logic RST_N;
    int   checks;
    int   failures;

    id_ex_operand_stage_if bus();

    id_ex_operand_stage dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, pc, ii, is, iu;
        logic [3:0]  fun;
        logic [1:0]  asel, bsel;
        logic        v, rw, mr, mw;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic [31:0] ea, eb, est;
        logic        ev, erw, emr, emw;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall = 1'b0;         bus.flush = 1'b0;
        bus.id_valid = 1'b0;      bus.id_pc = '0;
        bus.id_rs1_addr = '0;     bus.id_rs2_addr = '0;   bus.id_rd_addr = '0;
        bus.id_rs1_data = '0;     bus.id_rs2_data = '0;
        bus.id_imm_i = '0;        bus.id_imm_s = '0;      bus.id_imm_u = '0;
        bus.id_alu_fun = '0;      bus.id_srcA_sel = '0;   bus.id_srcB_sel = '0;
        bus.id_regwrite = 1'b0;   bus.id_memread = 1'b0;  bus.id_memwrite = 1'b0;
        bus.exm_regwrite = 1'b0;  bus.exm_rd_addr = '0;   bus.exm_result = '0;
        bus.mwb_regwrite = 1'b0;  bus.mwb_rd_addr = '0;   bus.mwb_result = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        bus.id_rs1_addr = v.rs1;  bus.id_rs2_addr = v.rs2;  bus.id_rd_addr = v.rd;
        bus.id_rs1_data = v.d1;   bus.id_rs2_data = v.d2;   bus.id_pc = v.pc;
        bus.id_imm_i = v.ii;      bus.id_imm_s = v.is;      bus.id_imm_u = v.iu;
        bus.id_alu_fun = v.fun;   bus.id_srcA_sel = v.asel; bus.id_srcB_sel = v.bsel;
        bus.id_valid = v.v;       bus.id_regwrite = v.rw;
        bus.id_memread = v.mr;    bus.id_memwrite = v.mw;
        bus.exm_regwrite = v.xw;  bus.exm_rd_addr = v.xrd;  bus.exm_result = v.xres;
        bus.mwb_regwrite = v.ww;  bus.mwb_rd_addr = v.wrd;  bus.mwb_result = v.wres;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //              rs1   rs2   rd     d1            d2            pc            imm_i         imm_s     imm_u         fun   as    bs    v     rw    mr    mw    xw    xrd   xres          ww    wrd   wres          expA          expB          expSt         ev    erw   emr   emw
        vecs[0] = '{5'd1, 5'd2, 5'd10, 32'd5,        32'd7,        32'h40,       32'h0,        32'h0,    32'h0,        4'h0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'd5,        32'd7,        32'd7,        1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{5'd3, 5'd4, 5'd11, 32'h11,       32'h22,       32'h44,       32'h0,        32'h0,    32'h0,        4'h8, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'hAA,       1'b1, 5'd3, 32'hBB,       32'hAA,       32'h22,       32'h22,       1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{5'd0, 5'd5, 5'd12, 32'h0,        32'h9,        32'h48,       32'h0,        32'h0,    32'h0,        4'h1, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h55,       1'b1, 5'd0, 32'h66,       32'h0,        32'h9,        32'h9,        1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{5'd1, 5'd6, 5'd0,  32'h3,        32'h99,       32'h200,      32'h0,        32'h10,   32'h0,        4'h0, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6, 32'h7,        1'b1, 5'd6, 32'h1234,     32'h200,      32'h10,       32'h1234,     1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{5'd2, 5'd3, 5'd13, 32'h1,        32'h2,        32'h204,      32'hFFFFFFF0, 32'h0,    32'h12345000, 4'h9, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h12345000, 32'hFFFFFFF0, 32'h2,        1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{5'd4, 5'd4, 5'd14, 32'hDEAD,     32'hBEEF,     32'h300,      32'h0,        32'h0,    32'h0,        4'hD, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h0,        32'h300,      32'hBEEF,     1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{5'd1, 5'd2, 5'd15, 32'h10,       32'h20,       32'h304,      32'h0,        32'h0,    32'h0,        4'h7, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h10,       32'h20,       32'h20,       1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{5'd5, 5'd0, 5'd16, 32'h1000,     32'h0,        32'h308,      32'h4,        32'h0,    32'h0,        4'h0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h1000,     32'h4,        32'h0,        1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{5'd7, 5'd7, 5'd18, 32'h77,       32'h77,       32'h30C,      32'h0,        32'h0,    32'h0,        4'h5, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h1,        1'b0, 5'd7, 32'h2,        32'h77,       32'h77,       32'h77,       1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{5'd8, 5'd9, 5'd17, 32'h80,       32'h0,        32'h310,      32'h0,        32'h0,    32'h0,        4'h6, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'hCAFE,     1'b1, 5'd8, 32'h808,      32'h808,      32'hCAFE,     32'hCAFE,     1'b1, 1'b1, 1'b0, 1'b0};

        // Reset with random decode fields; rs indices are cleared, so forwarding cannot leak in.
        clear_inputs();
        RST_N = 1'b0;
        bus.id_valid = 1'b1;  bus.id_regwrite = 1'b1;  bus.id_memread = 1'b1;  bus.id_memwrite = 1'b1;
        bus.id_pc = $urandom;  bus.id_rs1_data = $urandom;  bus.id_rs2_data = $urandom;
        bus.id_rs1_addr = 5'($urandom_range(1, 31));  bus.id_rs2_addr = 5'($urandom_range(1, 31));
        bus.id_rd_addr = 5'($urandom_range(1, 31));   bus.id_alu_fun = 4'($urandom);
        bus.id_imm_i = $urandom;  bus.id_imm_s = $urandom;  bus.id_imm_u = $urandom;
        bus.id_srcA_sel = 2'($urandom);  bus.id_srcB_sel = 2'($urandom);
        bus.exm_regwrite = 1'b1;  bus.exm_result = $urandom;
        bus.mwb_regwrite = 1'b1;  bus.mwb_result = $urandom;
        tick();
        tick();
        $display("reset: srcA=%h srcB=%h valid=%b", bus.srcA, bus.srcB, bus.ex_valid);
        check("rst_srcA",     bus.srcA, 32'h0);
        check("rst_srcB",     bus.srcB, 32'h0);
        check("rst_store",    bus.ex_store_data, 32'h0);
        check("rst_pc",       bus.ex_pc, 32'h0);
        check("rst_rd",       32'(bus.ex_rd_addr), 32'h0);
        check("rst_alu_fun",  32'(bus.alu_fun), 32'h0);
        check("rst_valid",    32'(bus.ex_valid), 32'h0);
        check("rst_regwrite", 32'(bus.ex_regwrite), 32'h0);
        check("rst_memread",  32'(bus.ex_memread), 32'h0);
        check("rst_memwrite", 32'(bus.ex_memwrite), 32'h0);
        RST_N = 1'b1;
        clear_inputs();

        for (int i = 0; i < 10; i++) begin
            drive_vec(vecs[i]);
            tick();
            $display("vec %0d: srcA=%h srcB=%h store=%h valid=%b rw=%b mr=%b mw=%b",
                     i, bus.srcA, bus.srcB, bus.ex_store_data,
                     bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite);
            check($sformatf("v%0d_srcA", i),     bus.srcA, vecs[i].ea);
            check($sformatf("v%0d_srcB", i),     bus.srcB, vecs[i].eb);
            check($sformatf("v%0d_store", i),    bus.ex_store_data, vecs[i].est);
            check($sformatf("v%0d_valid", i),    32'(bus.ex_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_regwrite", i), 32'(bus.ex_regwrite), 32'(vecs[i].erw));
            check($sformatf("v%0d_memread", i),  32'(bus.ex_memread), 32'(vecs[i].emr));
            check($sformatf("v%0d_memwrite", i), 32'(bus.ex_memwrite), 32'(vecs[i].emw));
            check($sformatf("v%0d_alu_fun", i),  32'(bus.alu_fun), 32'(vecs[i].fun));
            check($sformatf("v%0d_pc", i),       bus.ex_pc, vecs[i].pc);
            check($sformatf("v%0d_rd", i),       32'(bus.ex_rd_addr), 32'(vecs[i].rd));
        end

        // The forward path is combinational: retracting EX/MEM exposes MEM/WB, then the regfile value.
        drive_vec(vecs[1]);
        tick();
        check("dm_exm", bus.srcA, 32'hAA);
        bus.exm_regwrite = 1'b0;
        #1;
        $display("double-match: exm off srcA=%h", bus.srcA);
        check("dm_mwb", bus.srcA, 32'hBB);
        bus.mwb_regwrite = 1'b0;
        #1;
        check("dm_rf", bus.srcA, 32'h11);

        // Hold for three cycles while decode keeps changing, then flush during the stall.
        clear_inputs();
        bus.id_valid = 1'b1;  bus.id_regwrite = 1'b1;  bus.id_pc = 32'h100;
        bus.id_rs1_addr = 5'd1;  bus.id_rs1_data = 32'h5;  bus.id_rd_addr = 5'd9;
        tick();
        check("st_load_pc", bus.ex_pc, 32'h100);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.id_pc = 32'h900 + 32'(i);
            bus.id_rs1_data = 32'hF0;
            bus.id_valid = 1'b0;
            tick();
            $display("stall %0d: ex_pc=%h srcA=%h valid=%b", i, bus.ex_pc, bus.srcA, bus.ex_valid);
            check($sformatf("st%0d_pc", i),    bus.ex_pc, 32'h100);
            check($sformatf("st%0d_srcA", i),  bus.srcA, 32'h5);
            check($sformatf("st%0d_valid", i), 32'(bus.ex_valid), 32'h1);
        end
        bus.flush = 1'b1;
        tick();
        $display("flush+stall: valid=%b rw=%b pc=%h", bus.ex_valid, bus.ex_regwrite, bus.ex_pc);
        check("fl_valid",    32'(bus.ex_valid), 32'h0);
        check("fl_regwrite", 32'(bus.ex_regwrite), 32'h0);
        check("fl_pc",       bus.ex_pc, 32'h0);
        check("fl_srcA",     bus.srcA, 32'h0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        bus.id_valid = 1'b1;
        tick();
        check("rel_pc",    bus.ex_pc, 32'h902);
        check("rel_valid", 32'(bus.ex_valid), 32'h1);
        check("rel_srcA",  bus.srcA, 32'hF0);

        // Reset wins over stall.
        bus.stall = 1'b1;
        RST_N = 1'b0;
        tick();
        $display("reset+stall: valid=%b pc=%h", bus.ex_valid, bus.ex_pc);
        check("rs_valid", 32'(bus.ex_valid), 32'h0);
        check("rs_pc",    bus.ex_pc, 32'h0);
        RST_N = 1'b1;
        bus.stall = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
